// File: rtl/oup_ulpi_regaccess_seq_if.sv
// Register-access bus for the ULPI sequencer: requester side, syncmode-block
// execute side and status. Signal names carry the sequencer's point of view.
interface oup_ulpi_regaccess_seq_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_write_i;
  logic [5:0] req_addr_i;
  logic [7:0] req_data_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic [1:0] rsp_error_o;
  logic [7:0] instruction_o;
  logic       exec_o;
  logic       exec_done_i;
  logic       exec_aborted_i;
  logic [7:0] phyreg_data_o;
  logic [7:0] phyreg_addr_o;
  logic [7:0] phyreg_data_i;
  logic       busy_o;

  // Sequencer view.
  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i,
    input  exec_done_i, exec_aborted_i, phyreg_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o,
    output instruction_o, exec_o, phyreg_data_o, phyreg_addr_o, busy_o
  );

  // Environment view: requester plus syncmode block.
  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_data_i,
    output exec_done_i, exec_aborted_i, phyreg_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o,
    input  instruction_o, exec_o, phyreg_data_o, phyreg_addr_o, busy_o
  );
endinterface

// File: rtl/oup_ulpi_regaccess_seq.sv
// ULPI immediate register access sequencer: accepts one RegRead/RegWrite
// request, issues the TX CMD to the syncmode block, retries on abort, bounds
// the wait with a timeout and returns a single-cycle response.
module oup_ulpi_regaccess_seq #(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input logic                     ulpi_clk_i,
  input logic                     rst_ni,
  oup_ulpi_regaccess_seq_if.slave bus
);

  localparam logic [5:0]  IllegalAddr = 6'h2F;  // extended-address escape
  localparam logic [15:0] TimeoutLim  = 16'(TIMEOUT_CYC);
  localparam logic [3:0]  RetryMax    = 4'(MAX_RETRY);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrRetry   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [5:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  instr_q;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        accept;
  logic [15:0] cnt_inc;

  assign accept  = (state_q == StIdle) && bus.req_valid_i;
  assign cnt_inc = cnt_q + 16'd1;

  // Next-state logic; done beats abort, and both beat the timeout.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid_i) begin
          retry_d = 4'd0;
          if (bus.req_addr_i == IllegalAddr) begin
            state_d    = StResp;
            rsp_err_d  = ErrIllegal;
            rsp_data_d = 8'h00;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 16'd0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (bus.exec_done_i) begin
          state_d    = StResp;
          rsp_err_d  = ErrOk;
          rsp_data_d = write_q ? data_q : bus.phyreg_data_i;
        end else if (bus.exec_aborted_i) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 4'd1;
            state_d = StIssue;
          end else begin
            state_d    = StResp;
            rsp_err_d  = ErrRetry;
            rsp_data_d = 8'h00;
          end
        end else if (cnt_inc == TimeoutLim) begin
          state_d    = StResp;
          rsp_err_d  = ErrTimeout;
          rsp_data_d = 8'h00;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters and response registers.
  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      retry_q    <= 4'd0;
      cnt_q      <= 16'd0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Request capture on handshake; the command stays frozen until the next one.
  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_q <= 1'b0;
      addr_q  <= 6'd0;
      data_q  <= 8'h00;
      instr_q <= 8'h00;
    end else if (accept) begin
      write_q <= bus.req_write_i;
      addr_q  <= bus.req_addr_i;
      data_q  <= bus.req_data_i;
      instr_q <= {1'b1, ~bus.req_write_i, bus.req_addr_i};
    end
  end

  assign bus.req_ready_o   = (state_q == StIdle);
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.exec_o        = (state_q == StIssue);
  assign bus.rsp_valid_o   = (state_q == StResp);
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.rsp_error_o   = rsp_err_q;
  assign bus.instruction_o = instr_q;
  assign bus.phyreg_addr_o = {2'b00, addr_q};
  assign bus.phyreg_data_o = data_q;

endmodule
